// File: rtl/snail_pkg.sv
// Shared defaults and output-slot state encoding
// for the windowed match counter.
package snail_pkg;

  localparam int WIN_DEF = 8;
  localparam int CW_DEF  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/snail_match_counter_if.sv
// Result-slot bundle: match/enable/clear in,
// count with valid/ready handshake out.
interface snail_match_counter_if #(
  parameter int CW = 4
);

  logic          q;
  logic          en;
  logic          clr;
  logic          cnt_rdy;
  logic [CW-1:0] cnt;
  logic          cnt_vld;
  logic          sat;
  logic          ovf;

  modport master (
    input  q, en, clr, cnt_rdy,
    output cnt, cnt_vld, sat, ovf
  );

  modport slave (
    output q, en, clr, cnt_rdy,
    input  cnt, cnt_vld, sat, ovf
  );

endinterface

// File: rtl/snail_win_timer.sv
// Window position counter; flags the enabled
// edge that closes the current window.
module snail_win_timer
  import snail_pkg::*;
#(
  parameter int WIN = WIN_DEF
) (
  input  logic clk,
  input  logic _rst,
  input  logic en,
  input  logic clr,
  output logic win_end
);

  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WW-1:0] LAST = WW'(WIN - 1);

  logic [WW-1:0] r_win_cnt;

  assign win_end = en && (r_win_cnt == LAST);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_win_cnt <= '0;
    end else if (clr) begin
      r_win_cnt <= '0;
    end else if (win_end) begin
      r_win_cnt <= '0;
    end else if (en) begin
      r_win_cnt <= r_win_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/snail_match_counter.sv
// Counts detector matches per window and parks
// the result in a one-deep handshake slot.
module snail_match_counter
  import snail_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          _rst,
  input  logic          Q,
  input  logic          en,
  input  logic          clr,
  input  logic          cnt_rdy,
  output logic [CW-1:0] cnt,
  output logic          cnt_vld,
  output logic          sat,
  output logic          ovf
);

  localparam logic [CW-1:0] MAX = '1;

  logic          w_win_end;
  logic          w_inc;
  logic          w_acc_max;
  logic          w_sat_hit;
  logic [CW-1:0] w_result;

  logic [CW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_cnt_vld;
  logic          r_sat;
  logic          r_ovf;
  slot_e         r_state;

  snail_win_timer #(
    .WIN (WIN)
  ) u_timer (
    .clk     (clk),
    ._rst    (_rst),
    .en      (en),
    .clr     (clr),
    .win_end (w_win_end)
  );

  assign w_inc     = en & Q;
  assign w_acc_max = (r_acc == MAX);
  assign w_sat_hit = w_inc & w_acc_max;

  // Result includes the match seen on the closing edge itself.
  assign w_result = (w_inc && !w_acc_max) ?
                    r_acc + CW'(1) : r_acc;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_acc <= '0;
    end else if (clr || w_win_end) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_result;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state   <= EMPTY;
      r_cnt     <= '0;
      r_cnt_vld <= 1'b0;
      r_sat     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (clr) begin
      r_state   <= EMPTY;
      r_cnt     <= '0;
      r_cnt_vld <= 1'b0;
      r_sat     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_sat_hit) begin
        r_sat <= 1'b1;
      end
      unique case (r_state)
        EMPTY: begin
          if (w_win_end) begin
            r_cnt     <= w_result;
            r_cnt_vld <= 1'b1;
            r_state   <= FULL;
          end
        end
        FULL: begin
          // Unconsumed result wins; new one is dropped.
          if (w_win_end) begin
            if (cnt_rdy) begin
              r_cnt <= w_result;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (cnt_rdy) begin
            r_cnt_vld <= 1'b0;
            r_state   <= EMPTY;
          end
        end
      endcase
    end
  end

  assign cnt     = r_cnt;
  assign cnt_vld = r_cnt_vld;
  assign sat     = r_sat;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_snail_match_counter.sv
// Directed bench: vector table plus hand-written
// backpressure, saturation, clear and reset sequences.
module tb_snail_match_counter;

  typedef struct {
    logic       q;
    logic       en;
    logic       clr;
    logic       rdy;
    logic [3:0] cnt;
    logic       vld;
    logic       sat;
    logic       ovf;
  } vec_t;

  logic clk;
  logic rst;
  logic q, en, clr, rdy;

  int checks;
  int errors;

  vec_t tab[$];

  snail_match_counter_if #(.CW(4)) if4 ();
  snail_match_counter_if #(.CW(2)) if2 ();

  assign if4.q       = q;
  assign if4.en      = en;
  assign if4.clr     = clr;
  assign if4.cnt_rdy = rdy;
  assign if2.q       = q;
  assign if2.en      = en;
  assign if2.clr     = clr;
  assign if2.cnt_rdy = rdy;

  snail_match_counter #(.WIN(8), .CW(4)) u4 (
    .clk     (clk),
    ._rst    (rst),
    .Q       (if4.q),
    .en      (if4.en),
    .clr     (if4.clr),
    .cnt_rdy (if4.cnt_rdy),
    .cnt     (if4.cnt),
    .cnt_vld (if4.cnt_vld),
    .sat     (if4.sat),
    .ovf     (if4.ovf)
  );

  snail_match_counter #(.WIN(8), .CW(2)) u2 (
    .clk     (clk),
    ._rst    (rst),
    .Q       (if2.q),
    .en      (if2.en),
    .clr     (if2.clr),
    .cnt_rdy (if2.cnt_rdy),
    .cnt     (if2.cnt),
    .cnt_vld (if2.cnt_vld),
    .sat     (if2.sat),
    .ovf     (if2.ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Inputs are applied 3 units after an edge; outputs read 3 after the next.
  task automatic step(input logic q_i, input logic en_i,
                      input logic clr_i, input logic rdy_i);
    q   = q_i;
    en  = en_i;
    clr = clr_i;
    rdy = rdy_i;
    @(posedge clk);
    #3;
  endtask

  function automatic vec_t mk(input logic q_i, input logic en_i,
                              input logic clr_i, input logic rdy_i,
                              input logic [3:0] c, input logic v,
                              input logic s, input logic o);
    vec_t r;
    r.q = q_i; r.en = en_i; r.clr = clr_i; r.rdy = rdy_i;
    r.cnt = c; r.vld = v; r.sat = s; r.ovf = o;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    q = 1'b0; en = 1'b0; clr = 1'b0; rdy = 1'b1;

    #1;
    chk("rst.cnt", int'(if4.cnt), 0);
    chk("rst.vld", int'(if4.cnt_vld), 0);
    chk("rst.sat", int'(if4.sat), 0);
    chk("rst.ovf", int'(if4.ovf), 0);

    @(posedge clk);
    #3;
    rst = 1'b1;

    // Window of 8 with Q on cycles 0,3,7, then an empty window.
    tab.push_back(mk(1,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(1,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(1,1,0,1, 3,1,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 3,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,1,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    // Clear, 3 enabled cycles, 5 paused with Q high, then 5 enabled.
    tab.push_back(mk(0,1,1,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(1,0,0,1, 0,0,0,0));
    tab.push_back(mk(1,0,0,1, 0,0,0,0));
    tab.push_back(mk(1,0,0,1, 0,0,0,0));
    tab.push_back(mk(1,0,0,1, 0,0,0,0));
    tab.push_back(mk(1,0,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(0,1,0,1, 0,0,0,0));
    tab.push_back(mk(1,1,0,1, 1,1,0,0));
    tab.push_back(mk(0,1,0,1, 1,0,0,0));

    foreach (tab[i]) begin
      step(tab[i].q, tab[i].en, tab[i].clr, tab[i].rdy);
      chk($sformatf("vec%0d.cnt", i), int'(if4.cnt), int'(tab[i].cnt));
      chk($sformatf("vec%0d.vld", i), int'(if4.cnt_vld), int'(tab[i].vld));
      chk($sformatf("vec%0d.sat", i), int'(if4.sat), int'(tab[i].sat));
      chk($sformatf("vec%0d.ovf", i), int'(if4.ovf), int'(tab[i].ovf));
    end

    // Saturation on the 2-bit instance.
    step(0, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 1);
      if (i == 2) chk("sat.early", int'(if2.sat), 0);
      if (i == 3) chk("sat.hit", int'(if2.sat), 1);
    end
    chk("sat.cnt2", int'(if2.cnt), 3);
    chk("sat.vld2", int'(if2.cnt_vld), 1);
    chk("sat.cnt4", int'(if4.cnt), 8);
    chk("sat.sat4", int'(if4.sat), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1);
    chk("sat.next_cnt", int'(if2.cnt), 0);
    chk("sat.next_vld", int'(if2.cnt_vld), 1);
    chk("sat.sticky", int'(if2.sat), 1);
    step(0, 1, 1, 1);
    chk("sat.clr", int'(if2.sat), 0);

    // Backpressure across two window ends, ready on the third.
    for (int i = 0; i < 8; i++) step(i < 2, 1, 0, 0);
    chk("bp.a_cnt", int'(if4.cnt), 2);
    chk("bp.a_vld", int'(if4.cnt_vld), 1);
    chk("bp.a_ovf", int'(if4.ovf), 0);
    for (int i = 0; i < 8; i++) begin
      step(i < 5, 1, 0, 0);
      if (i == 3) chk("bp.b_hold", int'(if4.cnt), 2);
    end
    chk("bp.b_cnt", int'(if4.cnt), 2);
    chk("bp.b_ovf", int'(if4.ovf), 1);
    chk("bp.b_vld", int'(if4.cnt_vld), 1);
    for (int i = 0; i < 8; i++) step(i == 7, 1, 0, i == 7);
    chk("bp.c_cnt", int'(if4.cnt), 1);
    chk("bp.c_vld", int'(if4.cnt_vld), 1);
    chk("bp.c_ovf", int'(if4.ovf), 1);

    // Asynchronous reset mid-cycle with state held.
    q = 1'b1;
    en = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("arst.cnt", int'(if4.cnt), 0);
    chk("arst.vld", int'(if4.cnt_vld), 0);
    chk("arst.ovf", int'(if4.ovf), 0);
    chk("arst.sat4", int'(if4.sat), 0);
    chk("arst.sat2", int'(if2.sat), 0);
    en = 1'b0;
    #1;
    rst = 1'b1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("arst.idle", int'(if4.cnt_vld), 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 1);
    chk("arst.w7", int'(if4.cnt_vld), 0);
    step(1, 1, 0, 1);
    chk("arst.w8_cnt", int'(if4.cnt), 1);
    chk("arst.w8_vld", int'(if4.cnt_vld), 1);

    // Clear coincident with a window end while the slot is full.
    step(0, 1, 1, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    chk("cw.pre_vld", int'(if4.cnt_vld), 1);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("cw.cnt", int'(if4.cnt), 0);
    chk("cw.vld", int'(if4.cnt_vld), 0);
    chk("cw.sat", int'(if4.sat), 0);
    chk("cw.ovf", int'(if4.ovf), 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 1);
    chk("cw.w7", int'(if4.cnt_vld), 0);
    step(1, 1, 0, 1);
    chk("cw.w8_cnt", int'(if4.cnt), 1);
    chk("cw.w8_vld", int'(if4.cnt_vld), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snail_match_counter.md
SNAIL_MATCH_COUNTER -- requirements
Module: snail_match_counter

Interface
REQ-001 SHALL have parameter WIN, default 8, window length in clock cycles (range 2..256).
REQ-002 SHALL have parameter CW, default 4, width of the match count (range 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port _rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port Q  input  1  match pulse from the upstream 010 Mealy detector, sampled on clk rising edge.
REQ-006 SHALL have port en  input  1  count enable; low pauses the window.
REQ-007 SHALL have port clr  input  1  synchronous clear of all state.
REQ-008 SHALL have port cnt_rdy  input  1  consumer accepts cnt when high with cnt_vld.
REQ-009 SHALL have port cnt  output  CW  number of matches in the last completed window.
REQ-010 SHALL have port cnt_vld  output  1  cnt holds an unconsumed result.
REQ-011 SHALL have port sat  output  1  sticky: a window count saturated.
REQ-012 SHALL have port ovf  output  1  sticky: a window result was dropped under backpressure.

Function
REQ-013 SHALL keep a window counter win_cnt (0..WIN-1) that advances by one on each edge with en=1 and holds when en=0.
REQ-014 SHALL keep an accumulator acc (CW bits) that increments on each edge with en=1 and Q=1; Q is ignored while en=0.
REQ-015 SHALL saturate acc at 2^CW-1 and set sat on any attempted increment beyond it.
REQ-016 SHALL define window end as an edge with en=1 and win_cnt=WIN-1; at window end win_cnt wraps to 0 and acc clears to 0.
REQ-017 SHALL form the window result as acc plus the Q sample of the window-end edge, saturated per REQ-015.
REQ-018 SHALL run an output slot FSM with states EMPTY (cnt_vld=0) and FULL (cnt_vld=1).
REQ-019 EMPTY: at window end, load result into cnt and go to FULL; cnt_vld rises one edge after the last window cycle.
REQ-020 FULL with cnt_rdy=1 and no window end: go to EMPTY; cnt keeps its value.
REQ-021 FULL with cnt_rdy=1 and window end on the same edge: load new result, stay FULL.
REQ-022 FULL with cnt_rdy=0 and window end: keep old cnt, discard new result, set ovf, stay FULL.
REQ-023 SHALL hold cnt stable while cnt_vld=1 and cnt_rdy=0.
REQ-024 clr=1 SHALL on that edge zero win_cnt, acc, cnt, cnt_vld, sat, ovf, overriding every other event including a coincident window end.
REQ-025 sat and ovf SHALL clear only via clr or _rst.

Reset
REQ-026 _rst=0 SHALL immediately force win_cnt=0, acc=0, cnt=0, cnt_vld=0, sat=0, ovf=0, FSM=EMPTY, independent of clk.
REQ-027 After _rst deasserts, the first counted cycle SHALL be the first rising edge with en=1, starting a fresh window at win_cnt=0.
REQ-028 Reset mid-window or in FULL SHALL discard the partial window and any pending result.

Structure
REQ-029 Shared package snail_pkg SHALL hold default WIN, default CW, and the slot FSM state encoding (EMPTY, FULL).
REQ-030 The window counter with its wrap/end detection SHALL be a sub-module snail_win_timer (ports clk, _rst, en, clr, win_end).
REQ-031 All registers SHALL be in the clk domain; no combinational path from Q to any output.

Verification (bench drives Q three time units after clk rising edge; cnt_rdy=1 and en=1 unless stated)
REQ-032 Reset: pulse _rst low mid-cycle with prior nonzero state -> cnt=0, cnt_vld=0, sat=0, ovf=0 before the next edge.
REQ-033 WIN=8, CW=4, Q=1 on cycles 0,3,7 -> cnt=3, cnt_vld=1 for exactly one cycle after edge 8; next window with Q=0 -> cnt=0.
REQ-034 WIN=8, CW=2, Q=1 all 8 cycles -> cnt=3, sat=1, sat stays 1 through following windows until clr.
REQ-035 cnt_rdy=0 across two window ends with results 2 then 5 -> cnt stays 2, ovf=1; cnt_rdy=1 at a third window end with result 1 -> cnt=1, cnt_vld stays 1.
REQ-036 en=0 for 5 cycles after win_cnt=3 with Q=1 throughout the pause -> pause matches not counted, window ends 4 enabled cycles later.
REQ-037 clr coincident with window end and cnt_vld=1 -> all outputs 0 on that edge, next window starts at win_cnt=0.
